// File: rtl/dmem_lsu.sv
// Load/store unit in front of a word-indexed data memory: converts byte addresses
// to word indices, merges sub-word stores by read-modify-write, and extends loads.
module dmem_lsu #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  input  logic [31:0] mem_rdata
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the sender holds valid and its payload stable until that edge.

  typedef enum logic [2:0] {IDLE, LOAD, RMW, STORE, RESP} state_t;

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_t      state, state_nxt;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_uns;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] merged;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        req_err;
  logic [31:0] shifted;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] merge_w;

  assign accept    = req_valid && req_ready;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'd1:    req_err = req_addr[0];
      2'd2:    req_err = (req_addr[1:0] != 2'b00);
      2'd3:    req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (req_addr[31:2] >= DEPTH_W) req_err = 1'b1;
  end

  // Little-endian lane extraction and extension for loads.
  always_comb begin
    shifted  = mem_rdata >> {lat_addr[1:0], 3'b000};
    lane_h   = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext = mem_rdata;
    case (lat_size)
      2'd0:    load_ext = lat_uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = lat_uns ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    merge_w = mem_rdata;
    if (lat_size == 2'd0) merge_w[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
    else if (lat_addr[1]) merge_w[31:16] = lat_wdata[15:0];
    else merge_w[15:0] = lat_wdata[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_addr  = 32'd0;
    mem_wen   = 1'b0;
    mem_wdata = 32'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_err)            state_nxt = RESP;
          else if (!req_we)       state_nxt = LOAD;
          else if (req_size == 2) state_nxt = STORE;
          else                    state_nxt = RMW;
        end
      end
      LOAD: begin
        mem_addr  = {2'b00, lat_addr[31:2]};
        state_nxt = RESP;
      end
      RMW: begin
        mem_addr  = {2'b00, lat_addr[31:2]};
        state_nxt = STORE;
      end
      STORE: begin
        mem_addr  = {2'b00, lat_addr[31:2]};
        mem_wen   = 1'b1;
        mem_wdata = (lat_size == 2'd2) ? lat_wdata : merged;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_size  <= 2'd0;
      lat_uns   <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      merged    <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          lat_we    <= req_we;
          lat_size  <= req_size;
          lat_uns   <= req_unsigned;
          lat_addr  <= req_addr;
          lat_wdata <= req_wdata;
          merged    <= 32'd0;
          rdata_q   <= 32'd0;
          err_q     <= req_err;
        end
        LOAD: rdata_q <= load_ext;
        RMW:  merged  <= merge_w;
        RESP: if (rsp_ready) begin
          rdata_q <= 32'd0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit directly upstream of the 16-word, word-indexed data memory.
- Accepts byte/halfword/word load and store requests from the execute stage over a valid/ready handshake.
- Converts byte addresses to word indices, performs read-modify-write for sub-word stores, and sign/zero-extends load data.
- Flags misaligned and out-of-range accesses without touching memory, and returns one response per request over a valid/ready handshake.

Parameters:
- DEPTH, 16: number of 32-bit words in the data memory; legal word index is 0..DEPTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_we  input  1  1=store, 0=load.
- req_size  input  2  0=byte, 1=half, 2=word, 3=illegal.
- req_unsigned  input  1  loads only: 1=zero-extend, 0=sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; right-aligned for byte and half.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned, illegal-size or out-of-range request.
- mem_addr  output  32  word index to memory: zero-extended req_addr[31:2].
- mem_wdata  output  32  word to write.
- mem_wen  output  1  memory write enable, sampled by memory on clk rising edge.
- mem_rdata  input  32  combinational memory read data for mem_addr.

Behaviour:
- States: IDLE, LOAD, RMW, STORE, RESP. Registered state; mem_* outputs decode from state plus latched request.
- Reset, asynchronous: state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wen=0, mem_addr=0, mem_wdata=0, latched request cleared.
- Reset mid-operation: the operation is abandoned. mem_wen falls immediately and no write occurs after rst_n deasserts.
- IDLE: req_ready=1, mem_addr=0, mem_wen=0. Accept on req_valid&&req_ready and latch all request fields.
- Acceptance checks:
  - err if req_size==3; half with addr[0]!=0; word with addr[1:0]!=0; or addr[31:2]>=DEPTH.
  - On err: next state RESP with rsp_err=1, rsp_rdata=0, and no memory access.
- Next state after acceptance (no error):
  - load -> LOAD.
  - word store -> STORE.
  - byte/half store -> RMW.
- LOAD: mem_addr=word index. Capture mem_rdata, select lane (byte lane=addr[1:0], half lane=addr[1]; little-endian), extend per req_unsigned into rsp_rdata, then go to RESP.
- RMW: mem_addr=word index. Capture mem_rdata and merge req_wdata[7:0] or [15:0] into the addressed lane into an internal register, then go to STORE.
- STORE: mem_addr=word index, mem_wen=1 for exactly one cycle. mem_wdata is req_wdata for word stores, else the merged word. Then go to RESP with rsp_rdata=0.
- RESP:
  - rsp_valid=1 and rsp_rdata/rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, rsp_valid falls and state returns to IDLE.
  - A new request is accepted no earlier than the following cycle.
- Latency, acceptance edge T to first rsp_valid cycle:
  - error: T+1.
  - load or word store: T+2.
  - sub-word store: T+3.
- Requests arriving while req_ready=0 are ignored. The upstream stage holds req_valid and the request fields stable until accepted.
- Exactly one mem_wen pulse per successful store; none for loads or errors.

Test Plan:
- Reset, then word store addr=0x08 data=0xDEADBEEF, then word load addr=0x08 -> mem_wen pulses once with mem_addr=2; load rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid at T+2.
- With word 2 = 0xDEADBEEF: byte store addr=0x09 data=0x55 -> one mem_wen pulse, mem_wdata=0xDEAD55EF; then byte load addr=0x09 signed -> 0x00000055.
- With word 2 = 0xDEAD55EF: signed half load addr=0x0A -> 0xFFFFDEAD; unsigned -> 0x0000DEAD; signed byte addr=0x0B -> 0xFFFFFFDE.
- Errors:
  - Word load addr=0x06 -> rsp_err=1, rsp_rdata=0 at T+1, no memory access.
  - Store to addr=0x40 (index 16) -> rsp_err=1, no mem_wen.
  - req_size=3 -> rsp_err=1.
- Response backpressure: hold rsp_ready=0 for 5 cycles after a load -> rsp_valid and rsp_rdata stable, req_ready=0; the next request is accepted only after the handshake.
- Pull rst_n low while in RMW of a byte store -> outputs at reset values immediately, no mem_wen afterwards; the target word is unchanged on readback.
